// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP, and fetch-stage types.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux (JALR > JAL > taken branch > pc+4) with word-alignment check.
module next_pc_sel (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        branch,
  input  logic        jump,
  input  logic        is_jalr,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (jump && is_jalr) begin
      // JALR clears bit 0 of rs1+imm; masking keeps every input bit in use.
      next_pc = alu_result & 32'hFFFF_FFFE;
    end else if (jump) begin
      next_pc = pc + imm;
    end else if (branch && branch_taken) begin
      next_pc = pc + imm;
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch / PC-sequencing stage: FETCH -> EXEC loop, HALT on misaligned target.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  input  logic         stall,
  input  logic         branch,
  input  logic         jump,
  input  logic         is_jalr,
  input  logic         branch_taken,
  input  logic [31:0]  imm,
  input  logic [31:0]  alu_result,
  output logic [31:0]  instret,
  output logic         fetch_fault
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  instret_q;
  logic         fault_q;
  logic         req_q;
  logic         valid_q;
  logic [31:0]  next_pc_d;
  logic         misaligned_d;

  next_pc_sel u_next_pc_sel (
    .pc           (pc_q),
    .imm          (imm),
    .alu_result   (alu_result),
    .branch       (branch),
    .jump         (jump),
    .is_jalr      (is_jalr),
    .branch_taken (branch_taken),
    .next_pc      (next_pc_d),
    .misaligned   (misaligned_d)
  );

  // req/valid are registered alongside the state so they carry no input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
      fault_q   <= 1'b0;
      req_q     <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            instr_q <= imem.imem_rdata;
            state_q <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            instret_q <= instret_q + 32'd1;
            valid_q   <= 1'b0;
            if (misaligned_d) begin
              fault_q <= 1'b1;
              state_q <= HALT;
              req_q   <= 1'b0;
            end else begin
              pc_q    <= next_pc_d;
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_q <= HALT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign instret        = instret_q;
  assign fetch_fault    = fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC-sequencing stage of the RV32I core. It sits directly upstream of the opcode decoder: it holds the program counter, fetches each instruction word through a request/ready handshake, and presents it (opcode in bits [6:0]) to the decoder and datapath. The block computes the next PC from the decoder's Branch/Jump outcome and the datapath's branch/target results, and halts with a fault flag on a misaligned target.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- imem_req  out  1  fetch request, high throughout FETCH.
- imem_addr  out  32  word address of the fetch; equals pc.
- imem_ready  in  1  data-valid strobe; imem_rdata is sampled on the edge where imem_req & imem_ready.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction; drives the decoder (opcode = instr[6:0]).
- instr_valid  out  1  high while instr is being executed (EXEC state).
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, for JAL/JALR link write-back.
- stall  in  1  downstream hold; freezes EXEC.
- branch  in  1  decoder Branch.
- jump  in  1  decoder Jump (JAL or JALR).
- is_jalr  in  1  high for opcode 1100111; qualifies jump.
- branch_taken  in  1  datapath compare result.
- imm  in  32  sign-extended B/J immediate.
- alu_result  in  32  JALR target (rs1 + imm).
- instret  out  32  retired-instruction counter.
- fetch_fault  out  1  sticky misaligned-target flag.

## Operation
- States: FETCH, EXEC, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, state<=EXEC. imem_addr is stable until ready.
- EXEC: instr_valid=1. If stall=1, all state holds and next-PC inputs are ignored. If stall=0, next_pc is computed, instret increments, and:
  - next_pc[1:0]==0: pc<=next_pc, state<=FETCH.
  - otherwise: fetch_fault<=1, state<=HALT, pc unchanged (points at the faulting instruction).
- next_pc priority:
  1. jump & is_jalr: {alu_result[31:1],1'b0}
  2. jump: pc+imm
  3. branch & branch_taken: pc+imm
  4. else: pc+4
- Arithmetic: all sums are 32-bit modulo 2^32; pc wraps 0xFFFF_FFFC+4 -> 0x0000_0000. instret wraps at 2^32-1 -> 0.
- HALT: imem_req=0, instr_valid=0. Only reset exits.
- imem_ready outside FETCH is ignored.

## Timing
- Reset values (edge with rst_n=0): state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0, fetch_fault=0. Hence imem_req=1 and instr_valid=0 in the first cycle after reset.
- Reset dominates every input, including an imem_ready or EXEC completion in the same cycle. Reset mid-fetch abandons the request.
- Latency: request at cycle N with ready at N -> instr_valid at N+1. With zero-wait memory and no stall, throughput is 1 instruction / 2 cycles.
- imem_req, instr_valid, and imem_addr are decoded from registered state and pc only; there is no combinational input-to-output path on these signals.
- pc_plus4 is combinational from pc.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OP_JALR=7'b1100111 etc.)
  - NOP_INSTR=32'h0000_0013
  - fetch state enum {FETCH, EXEC, HALT}
  - default RESET_PC
- Sub-module next_pc_sel: combinational priority mux plus the alignment check; outputs next_pc and misaligned.

## Test plan
- Reset, then release, with imem_ready=1 always and NOPs -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid every second cycle; instret=3 after three EXECs.
- Wait states: imem_ready asserted 3 cycles after the request -> imem_addr held at 0x4 for all 3 cycles; instr captures the word present on the ready cycle only.
- Branch at pc=0x10 with imm=0xFFFF_FFF8: taken -> next imem_addr 0x8; not taken -> 0x14; JAL imm=0x100 -> 0x110.
- JALR with alu_result=0x0000_0101 -> next pc 0x100 and pc_plus4=pc+4. jump, is_jalr, and branch all high -> JALR target wins.
- stall held 4 cycles in EXEC while imm/branch toggle -> pc, instr, and instret frozen; advance on the first stall=0 edge.
- JAL at pc=0x20 with imm=0x6 -> fetch_fault=1, HALT, pc=0x20, imem_req=0. Then rst_n=0 for one edge -> pc=RESET_PC, fault cleared, fetch resumes.
